// File: rtl/mul_pkg.sv
// Shared widths, op and FSM encodings, and operand helpers for the mul_unit
// multiplier slice (booth_multiplier and mul_unit).
package mul_pkg;

  localparam int OPW = 32;
  localparam int MW  = 34;
  localparam int PW  = 68;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_MULH  = 2'b01,
    OP_MULHU = 2'b10,
    OP_RSVD  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  // Two guard bits let one signed 34x34 core serve both signed and unsigned ops.
  function automatic logic [MW-1:0] extend_operand(input op_t op, input logic [OPW-1:0] v);
    if (op == OP_MULHU) return {2'b00, v};
    return {{(MW-OPW){v[OPW-1]}}, v};
  endfunction

  function automatic logic is_high_half(input op_t op);
    return (op == OP_MULH) || (op == OP_MULHU);
  endfunction

endpackage

// File: rtl/booth_multiplier.sv
// Radix-4 Booth 34x34 signed multiplier with a single registered output stage.
module booth_multiplier
  import mul_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [MW-1:0] a,
  input  logic [MW-1:0] b,
  output logic [PW-1:0] product
);

  localparam int NDIG = MW / 2;

  logic [PW-1:0] a_ext;
  logic [MW:0]   b_ext;
  logic [PW-1:0] pp [NDIG];
  logic [PW-1:0] sum;

  assign a_ext = {{(PW-MW){a[MW-1]}}, a};
  assign b_ext = {b, 1'b0};

  // Each overlapping bit triplet of b selects a digit in {-2,-1,0,+1,+2}.
  for (genvar gi = 0; gi < NDIG; gi++) begin : g_pp
    logic [2:0]    trip;
    logic [PW-1:0] mag;

    assign trip = b_ext[2*gi+2 -: 3];

    always_comb begin
      mag = '0;
      case (trip)
        3'b001, 3'b010: mag = a_ext;
        3'b011:         mag = a_ext << 1;
        3'b100:         mag = -(a_ext << 1);
        3'b101, 3'b110: mag = -a_ext;
        default:        mag = '0;
      endcase
    end

    assign pp[gi] = mag << (2 * gi);
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < NDIG; i++) begin
      sum = sum + pp[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      product <= '0;
    end else begin
      product <= sum;
    end
  end

endmodule

// File: rtl/mul_unit.sv
// Handshaked 32-bit mul.w / mulh.w / mulh.wu unit around booth_multiplier.
// Define MUL_PIPE_EN to allow a new request to be accepted while a result drains.
module mul_unit
  import mul_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [OPW-1:0]   in_src1,
  input  logic [OPW-1:0]   in_src2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OPW-1:0]   out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  state_t           state_reg, state_next;
  op_t              op_reg;
  logic [TAG_W-1:0] tag_reg;
  logic [MW-1:0]    src1_reg, src2_reg;
  logic [PW-1:0]    product;
  logic             accept;
  op_t              in_op_t;

  assign in_op_t = op_t'(in_op);

`ifdef MUL_PIPE_EN
  assign in_ready = ((state_reg == IDLE) || (state_reg == DONE && out_ready)) && !flush && !reset;
`else
  assign in_ready = (state_reg == IDLE) && !flush && !reset;
`endif

  assign accept    = in_valid && in_ready;
  assign out_valid = (state_reg == DONE) && !flush && !reset;
  assign busy      = (state_reg != IDLE) && !reset;
  assign out_tag   = reset ? '0 : tag_reg;

  always_comb begin
    out_result = product[OPW-1:0];
    if (is_high_half(op_reg)) out_result = product[2*OPW-1:OPW];
    if (reset) out_result = '0;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = CALC;
      CALC: state_next = DONE;
      DONE: begin
        if (accept)         state_next = CALC;
        else if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  // Operands only move on accept, so the registered product holds while DONE stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      op_reg    <= OP_MUL;
      tag_reg   <= '0;
      src1_reg  <= '0;
      src2_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        op_reg   <= in_op_t;
        tag_reg  <= in_tag;
        src1_reg <= extend_operand(in_op_t, in_src1);
        src2_reg <= extend_operand(in_op_t, in_src2);
      end
    end
  end

  booth_multiplier u_core (
    .clk     (clk),
    .reset   (reset),
    .a       (src1_reg),
    .b       (src2_reg),
    .product (product)
  );

endmodule

// File: tb/tb_mul_unit.sv
// Directed self-checking bench for mul_unit: latency, op results, stall, flush, reset, throughput.
module tb_mul_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_src1;
  logic [31:0] in_src2;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
  logic        busy;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  mul_unit #(.TAG_W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Accept in cycle N, expect out_valid with result/tag in N+2, idle in N+3.
  task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp);
    in_op = op; in_src1 = a; in_src2 = b; in_tag = tag; in_valid = 1'b1;
    #1;
    check({name, "_in_ready"}, 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check({name, "_valid_n1"}, 64'(out_valid), 64'd0);
    check({name, "_busy_n1"}, 64'(busy), 64'd1);
    tick();
    check({name, "_valid_n2"}, 64'(out_valid), 64'd1);
    check({name, "_result"}, 64'(out_result), 64'(exp));
    check({name, "_tag"}, 64'(out_tag), 64'(tag));
    $display("op %s: %h x %h -> %h tag %0d", name, a, b, out_result, out_tag);
    tick();
    check({name, "_valid_n3"}, 64'(out_valid), 64'd0);
    check({name, "_busy_n3"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic        acc;
    int          idx;
    int          nres;
    int          cyc0, cyc1;
    logic [31:0] r0, r1;
    int          exp_gap;

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = 2'b00; in_src1 = '0; in_src2 = '0; in_tag = '0;
    tick();
    tick();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_result", 64'(out_result), 64'd0);
    check("rst_tag", 64'(out_tag), 64'd0);
    reset = 1'b0;
    #1;
    check("rst_release_in_ready", 64'(in_ready), 64'd1);

    do_op("mulw_neg1x2",   2'b00, 32'hFFFFFFFF, 32'h00000002, 5'd7,  32'hFFFFFFFE);
    do_op("mulh_min_sq",   2'b01, 32'h80000000, 32'h80000000, 5'd1,  32'h40000000);
    do_op("mulhu_max_sq",  2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE);
    do_op("mulh_neg1_sq",  2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'h00000000);
    do_op("rsvd_as_mulw",  2'b11, 32'h12345678, 32'h00000010, 5'd4,  32'h23456780);
    do_op("mulhu_min_x2",  2'b10, 32'h80000000, 32'h00000002, 5'd12, 32'h00000001);
    do_op("mulh_min_x2",   2'b01, 32'h80000000, 32'h00000002, 5'd13, 32'hFFFFFFFF);

    // Stall in DONE for 5 cycles
    out_ready = 1'b0;
    in_op = 2'b00; in_src1 = 32'h1234; in_src2 = 32'h10; in_tag = 5'd9; in_valid = 1'b1;
    #1;
    check("stall_accept", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_result", 64'(out_result), 64'h12340);
      check("stall_tag", 64'(out_tag), 64'd9);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_busy", 64'(busy), 64'd1);
      $display("stall cycle %0d: valid=%0d result=%h tag=%0d", i, out_valid, out_result, out_tag);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("stall_release_valid", 64'(out_valid), 64'd1);
    tick();
    check("stall_done_valid", 64'(out_valid), 64'd0);
    check("stall_done_busy", 64'(busy), 64'd0);

    // Flush while in CALC
    in_op = 2'b00; in_src1 = 32'd7; in_src2 = 32'd7; in_tag = 5'd5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    flush = 1'b1;
    #1;
    check("flush_calc_in_ready", 64'(in_ready), 64'd0);
    check("flush_calc_valid", 64'(out_valid), 64'd0);
    tick();
    flush = 1'b0;
    #1;
    check("flush_calc_busy", 64'(busy), 64'd0);
    check("flush_calc_in_ready_after", 64'(in_ready), 64'd1);
    for (int i = 0; i < 2; i++) begin
      check("flush_calc_no_valid", 64'(out_valid), 64'd0);
      tick();
    end
    $display("flush in CALC: busy=%0d out_valid=%0d", busy, out_valid);
    do_op("after_flush_3x5", 2'b00, 32'd3, 32'd5, 5'd8, 32'h0000000F);

    // Flush while in DONE suppresses delivery
    in_op = 2'b00; in_src1 = 32'd6; in_src2 = 32'd6; in_tag = 5'd14; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    flush = 1'b1;
    #1;
    check("flush_done_valid", 64'(out_valid), 64'd0);
    tick();
    flush = 1'b0;
    #1;
    check("flush_done_busy", 64'(busy), 64'd0);
    check("flush_done_no_valid", 64'(out_valid), 64'd0);
    $display("flush in DONE: busy=%0d out_valid=%0d", busy, out_valid);

    // Reset mid-operation
    in_op = 2'b00; in_src1 = 32'd9; in_src2 = 32'd9; in_tag = 5'd6; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_mid_valid", 64'(out_valid), 64'd0);
    check("rst_mid_in_ready", 64'(in_ready), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_result", 64'(out_result), 64'd0);
    check("rst_mid_tag", 64'(out_tag), 64'd0);
    tick();
    reset = 1'b0;
    #1;
    check("rst_mid_release_ready", 64'(in_ready), 64'd1);
    check("rst_mid_release_busy", 64'(busy), 64'd0);
    check("rst_mid_release_result", 64'(out_result), 64'd0);
    for (int i = 0; i < 3; i++) begin
      check("rst_mid_no_valid", 64'(out_valid), 64'd0);
      tick();
    end
    $display("reset mid-op: busy=%0d out_valid=%0d", busy, out_valid);

    // Back-to-back throughput
`ifdef MUL_PIPE_EN
    exp_gap = 2;
`else
    exp_gap = 3;
`endif
    idx = 0; nres = 0; cyc0 = 0; cyc1 = 0; r0 = '0; r1 = '0;
    out_ready = 1'b1;
    in_op = 2'b00; in_src1 = 32'd2; in_src2 = 32'd3; in_tag = 5'd10; in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        if (idx == 0) begin
          in_src1 = 32'd4; in_src2 = 32'd5; in_tag = 5'd11; idx = 1;
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid && out_ready) begin
        if (nres == 0) begin r0 = out_result; cyc0 = c; end
        else if (nres == 1) begin r1 = out_result; cyc1 = c; end
        nres++;
      end
    end
    in_valid = 1'b0;
    $display("back-to-back: r0=%0d@%0d r1=%0d@%0d count=%0d", r0, cyc0, r1, cyc1, nres);
    check("b2b_count", 64'(nres), 64'd2);
    check("b2b_r0", 64'(r0), 64'd6);
    check("b2b_r1", 64'(r1), 64'd20);
    check("b2b_gap", 64'(cyc1 - cyc0), 64'(exp_gap));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
